// File: rtl/util_sync_edge_filter_if.sv
// rtl/util_sync_edge_filter_if.sv - signal bundle between synchronizer consumer and edge filter
interface util_sync_edge_filter_if #(
  parameter int CNT_WIDTH = 16
);
  logic                 d_sync;
  logic                 level;
  logic                 rise;
  logic                 fall;
  logic                 evt_pending;
  logic                 evt_ack;
  logic [CNT_WIDTH-1:0] evt_count;
  logic                 evt_count_clr;
  logic                 overrun;

  // Status/control side: feeds the synchronized level and services events
  modport master (
    output d_sync, evt_ack, evt_count_clr,
    input  level, rise, fall, evt_pending, evt_count, overrun
  );

  // Filter side
  modport slave (
    input  d_sync, evt_ack, evt_count_clr,
    output level, rise, fall, evt_pending, evt_count, overrun
  );
endinterface

// File: rtl/util_sync_edge_filter.sv
// rtl/util_sync_edge_filter.sv - glitch filter with edge pulses, pending/ack, counter and overrun
module util_sync_edge_filter #(
  parameter int   FILTER_CYCLES = 4,
  parameter int   CNT_WIDTH     = 16,
  parameter logic RESET_VALUE   = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  util_sync_edge_filter_if.slave  bus
);

  localparam int FW = $clog2(FILTER_CYCLES + 1);
  localparam logic [FW-1:0]        FCNT_LAST = FW'(FILTER_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

  typedef enum logic {STABLE, CANDIDATE} state_t;

  state_t               state_q;
  logic [FW-1:0]        fcnt_q;
  logic                 level_q;
  logic                 rise_q;
  logic                 fall_q;
  logic                 pending_q;
  logic                 overrun_q;
  logic [CNT_WIDTH-1:0] count_q;

  logic differs;
  logic commit;

  // Decide whether this sample completes a run long enough to flip the level
  always_comb begin
    differs = (bus.d_sync != level_q);
    commit  = 1'b0;
    if (differs) begin
      if (FILTER_CYCLES == 1) begin
        commit = 1'b1;
      end else if ((state_q == CANDIDATE) && (fcnt_q == FCNT_LAST)) begin
        commit = 1'b1;
      end
    end
  end

  // Filter state machine with registered level and one-cycle edge pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= STABLE;
      fcnt_q  <= '0;
      level_q <= RESET_VALUE;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      if (commit) begin
        level_q <= ~level_q;
        rise_q  <= ~level_q;
        fall_q  <= level_q;
        state_q <= STABLE;
        fcnt_q  <= '0;
      end else begin
        case (state_q)
          STABLE: begin
            if (differs) begin
              state_q <= CANDIDATE;
              fcnt_q  <= FW'(1);
            end else begin
              fcnt_q  <= '0;
            end
          end
          CANDIDATE: begin
            if (!differs) begin
              // Input fell back before the run was long enough: a glitch
              state_q <= STABLE;
              fcnt_q  <= '0;
            end else begin
              fcnt_q  <= fcnt_q + 1'b1;
            end
          end
          default: begin
            state_q <= STABLE;
            fcnt_q  <= '0;
          end
        endcase
      end
    end
  end

  // Event bookkeeping: a new edge always wins over ack and clear
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      count_q   <= '0;
    end else begin
      pending_q <= commit | (pending_q & ~bus.evt_ack);

      if (commit && pending_q && !bus.evt_ack) begin
        overrun_q <= 1'b1;
      end else if (bus.evt_count_clr) begin
        overrun_q <= 1'b0;
      end

      if (bus.evt_count_clr) begin
        count_q <= commit ? CNT_WIDTH'(1) : '0;
      end else if (commit && (count_q != CNT_MAX)) begin
        count_q <= count_q + 1'b1;
      end
    end
  end

  assign bus.level       = level_q;
  assign bus.rise        = rise_q;
  assign bus.fall        = fall_q;
  assign bus.evt_pending = pending_q;
  assign bus.overrun     = overrun_q;
  assign bus.evt_count   = count_q;

endmodule

// File: tb/tb_util_sync_edge_filter.sv
// tb/tb_util_sync_edge_filter.sv - self-checking bench for util_sync_edge_filter
module tb_util_sync_edge_filter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst_v, d_v, ack_v, clr_v;

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  // Instance 0: default filter; 1: narrow counter; 2: no filtering
  localparam int FC [3] = '{4, 4, 1};
  localparam int CW [3] = '{16, 3, 16};

  util_sync_edge_filter_if #(.CNT_WIDTH(16)) if0 ();
  util_sync_edge_filter_if #(.CNT_WIDTH(3))  if1 ();
  util_sync_edge_filter_if #(.CNT_WIDTH(16)) if2 ();

  assign if0.d_sync = d_v[0];  assign if0.evt_ack = ack_v[0];  assign if0.evt_count_clr = clr_v[0];
  assign if1.d_sync = d_v[1];  assign if1.evt_ack = ack_v[1];  assign if1.evt_count_clr = clr_v[1];
  assign if2.d_sync = d_v[2];  assign if2.evt_ack = ack_v[2];  assign if2.evt_count_clr = clr_v[2];

  util_sync_edge_filter #(.FILTER_CYCLES(4), .CNT_WIDTH(16), .RESET_VALUE(1'b0)) dut0 (
    .clk(clk), .rst(rst_v[0]), .bus(if0));
  util_sync_edge_filter #(.FILTER_CYCLES(4), .CNT_WIDTH(3), .RESET_VALUE(1'b0)) dut1 (
    .clk(clk), .rst(rst_v[1]), .bus(if1));
  util_sync_edge_filter #(.FILTER_CYCLES(1), .CNT_WIDTH(16), .RESET_VALUE(1'b0)) dut2 (
    .clk(clk), .rst(rst_v[2]), .bus(if2));

  logic [2:0]  lvl_o, rise_o, fall_o, pend_o, ovr_o;
  logic [31:0] cnt_o [3];
  assign lvl_o  = {if2.level, if1.level, if0.level};
  assign rise_o = {if2.rise, if1.rise, if0.rise};
  assign fall_o = {if2.fall, if1.fall, if0.fall};
  assign pend_o = {if2.evt_pending, if1.evt_pending, if0.evt_pending};
  assign ovr_o  = {if2.overrun, if1.overrun, if0.overrun};
  assign cnt_o[0] = 32'(if0.evt_count);
  assign cnt_o[1] = 32'(if1.evt_count);
  assign cnt_o[2] = 32'(if2.evt_count);

  // Model: the level flips once the most recent FC samples since the last
  // reset/flip all disagree with it; events follow from that flip.
  typedef struct packed {
    logic [31:0] win;
    int          nsamp;
    logic        lvl, rise, fall, pend, ovr;
    int          cnt;
  } mst_t;

  mst_t m [3];

  function automatic mst_t step(mst_t s, logic r, logic d, logic ack, logic clr, int f, int cw);
    mst_t n = s;
    logic [31:0] mask;
    bit ev;
    if (r) begin
      n = '0;
      return n;
    end
    n.win   = {s.win[30:0], d};
    n.nsamp = (s.nsamp + 1 > f) ? f : s.nsamp + 1;
    mask    = (32'd1 << f) - 32'd1;
    ev      = (n.nsamp == f) && ((n.win & mask) == (s.lvl ? 32'd0 : mask));
    n.rise  = ev && !s.lvl;
    n.fall  = ev && s.lvl;
    if (ev) begin
      n.lvl   = !s.lvl;
      n.nsamp = 0;
    end
    n.pend = ev ? 1'b1 : (ack ? 1'b0 : s.pend);
    n.ovr  = (ev && s.pend && !ack) ? 1'b1 : (clr ? 1'b0 : s.ovr);
    if (clr)     n.cnt = ev ? 1 : 0;
    else if (ev) n.cnt = (s.cnt == (1 << cw) - 1) ? s.cnt : s.cnt + 1;
    return n;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++)
      m[i] <= step(m[i], rst_v[i], d_v[i], ack_v[i], clr_v[i], FC[i], CW[i]);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Every-cycle comparison of all instances against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("i%0d_level", i),   32'(lvl_o[i]),  32'(m[i].lvl));
        chk($sformatf("i%0d_rise", i),    32'(rise_o[i]), 32'(m[i].rise));
        chk($sformatf("i%0d_fall", i),    32'(fall_o[i]), 32'(m[i].fall));
        chk($sformatf("i%0d_pending", i), 32'(pend_o[i]), 32'(m[i].pend));
        chk($sformatf("i%0d_overrun", i), 32'(ovr_o[i]),  32'(m[i].ovr));
        chk($sformatf("i%0d_count", i),   cnt_o[i],       32'(m[i].cnt));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_v = 3'b111; d_v = '0; ack_v = '0; clr_v = '0;
    tick();
    cmp_en = 1'b1;
    tick(); tick();
    rst_v = '0;
    chk("rst_level", 32'(if0.level), 0);
    chk("rst_pending", 32'(if0.evt_pending), 0);
    chk("rst_count", cnt_o[0], 0);
    chk("rst_overrun", 32'(if0.overrun), 0);

    // Three-sample glitch is rejected
    d_v[0] = 1'b1;
    repeat (3) tick();
    d_v[0] = 1'b0;
    repeat (4) tick();
    chk("glitch_level", 32'(if0.level), 0);
    chk("glitch_count", cnt_o[0], 0);

    // Valid rise: visible after the fourth sample
    d_v[0] = 1'b1;
    repeat (3) tick();
    chk("rise_early_level", 32'(if0.level), 0);
    tick();
    chk("rise_level", 32'(if0.level), 1);
    chk("rise_pulse", 32'(if0.rise), 1);
    chk("rise_pending", 32'(if0.evt_pending), 1);
    chk("rise_count", cnt_o[0], 1);
    tick();
    chk("rise_pulse_end", 32'(if0.rise), 0);
    repeat (8) tick();

    // Fall without ack gives overrun
    d_v[0] = 1'b0;
    repeat (4) tick();
    chk("fall_pulse", 32'(if0.fall), 1);
    chk("fall_count", cnt_o[0], 2);
    chk("fall_overrun", 32'(if0.overrun), 1);

    // Ack coincident with third edge: pending stays set
    d_v[0] = 1'b1;
    repeat (3) tick();
    ack_v[0] = 1'b1;
    tick();
    chk("ackcol_pending", 32'(if0.evt_pending), 1);
    chk("ackcol_count", cnt_o[0], 3);
    tick();
    ack_v[0] = 1'b0;
    chk("ack_alone_pending", 32'(if0.evt_pending), 0);

    // Build count to 5, then clear coincident with an edge
    d_v[0] = 1'b0;
    repeat (4) tick();
    d_v[0] = 1'b1;
    repeat (4) tick();
    chk("pre_clr_count", cnt_o[0], 5);
    chk("pre_clr_overrun", 32'(if0.overrun), 1);
    d_v[0] = 1'b0;
    repeat (3) tick();
    clr_v[0] = 1'b1;
    tick();
    clr_v[0] = 1'b0;
    chk("clrcol_count", cnt_o[0], 1);
    chk("clrcol_overrun", 32'(if0.overrun), 1);
    tick();
    clr_v[0] = 1'b1;
    tick();
    clr_v[0] = 1'b0;
    chk("clr_count", cnt_o[0], 0);
    chk("clr_overrun", 32'(if0.overrun), 0);

    // Reset in the middle of a candidate run
    d_v[0] = 1'b1;
    tick(); tick();
    rst_v[0] = 1'b1;
    tick();
    rst_v[0] = 1'b0;
    chk("midrst_level", 32'(if0.level), 0);
    chk("midrst_rise", 32'(if0.rise), 0);
    repeat (3) tick();
    chk("postrst_early_level", 32'(if0.level), 0);
    tick();
    chk("postrst_rise", 32'(if0.rise), 1);
    chk("postrst_count", cnt_o[0], 1);

    // Saturating counter on the 3-bit instance
    for (int k = 0; k < 9; k++) begin
      d_v[1] = ~d_v[1];
      repeat (4) tick();
      if (k == 6) chk("sat_count_7", cnt_o[1], 7);
    end
    chk("sat_count_hold", cnt_o[1], 7);

    // No filtering: one-cycle glitch yields rise then fall
    d_v[2] = 1'b1;
    tick();
    chk("nf_level_hi", 32'(if2.level), 1);
    chk("nf_rise", 32'(if2.rise), 1);
    d_v[2] = 1'b0;
    tick();
    chk("nf_level_lo", 32'(if2.level), 0);
    chk("nf_fall", 32'(if2.fall), 1);
    chk("nf_count", cnt_o[2], 2);
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
